mux_arb_nto1: RTL
=================

# mux_arb_nto1

Parametrised, registered N-to-1 channel multiplexer with valid/ready handshaking on every input and on the output. It generalises the 16:1 32-bit combinational mux used in the ALU datapath. It adds two selection modes, fixed select and round-robin arbitration, plus a single output register stage for timing closure. It sits between multiple result or operand producers and a single downstream consumer.

## Interface
- WIDTH, 32: data width per channel.
- CHANNELS, 16: number of input channels, ≥2, need not be a power of two.
- SEL_W, $clog2(CHANNELS): select/channel-index width. Derived; do not override.

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mode  in  1  0 = MODE_SEL (fixed select), 1 = MODE_RR (round-robin).
- sel  in  SEL_W  channel index used in MODE_SEL.
- in_data  in  CHANNELS*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  CHANNELS  per-channel valid.
- in_ready  out  CHANNELS  per-channel ready; at most one bit is high per cycle.
- out_data  out  WIDTH  registered selected word.
- out_chan  out  SEL_W  index of the channel that produced out_data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  downstream accepts.

## Operation
- `accept = !out_valid || out_ready`. The output register loads whenever it is empty or being drained in the same cycle.
- Grant, combinational from the current cycle's inputs:
  - MODE_SEL: grant channel `sel` iff `in_valid[sel]` and `sel < CHANNELS`. An out-of-range `sel` grants nothing and never stalls other logic.
  - MODE_RR: grant the first channel with `in_valid` set, searching upward from `ptr+1` modulo CHANNELS. `ptr` is the last channel granted in RR mode.
- `in_ready[k] = accept && grant_onehot[k]`. A transfer on channel k occurs when `in_valid[k] && in_ready[k]`.
- On a transfer:
  - out_data ← channel word, out_chan ← k, out_valid ← 1.
  - In MODE_RR only, ptr ← k.
- With no transfer, if `out_valid && out_ready` then out_valid ← 0. out_data and out_chan hold their values.
- While `out_valid && !out_ready`:
  - out_data, out_chan and out_valid are stable.
  - All in_ready bits are 0.
- ptr is retained across mode changes. MODE_SEL grants never update ptr.
- `mode` and `sel` are sampled every cycle. A change affects only the next grant, never a word already held.

## Timing
- Reset values:
  - out_valid = 0, out_data = 0, out_chan = 0.
  - ptr = CHANNELS-1, so the first RR grant favours channel 0.
  - in_ready = 0, because out_valid = 0 but no grant is valid until inputs assert.
- Latency: 1 cycle. A word accepted at edge n is visible on out_data after edge n.
- Throughput: 1 word per cycle with out_ready held high. A simultaneous drain and load is a replacement with no bubble.
- RR fairness: with all CHANNELS inputs continuously valid and out_ready = 1, the grant order is 0,1,…,CHANNELS-1,0,… with one grant per cycle.
- A single valid requester is granted every accepting cycle, with no idle slot.
- Reset asserted mid-operation clears the held word immediately (asynchronous) and discards it. ptr returns to CHANNELS-1.
- in_valid may drop without a handshake. The block must not latch data except on a transfer.

## Structure
- Shared package `mux_arb_pkg` holds:
  - the mode constants MODE_SEL = 1'b0 and MODE_RR = 1'b1;
  - the function clog2_safe, which returns 1 for CHANNELS ≤ 2.
- Sub-module `rr_grant`: purely combinational rotating-priority encoder. Inputs: req[CHANNELS-1:0] and ptr. Outputs: a one-hot grant plus its index and an any-grant flag. Instantiated once.
- The top level holds the output register, ptr and the mode mux.

## Test plan
- Reset/idle: rst_n = 0, then 1 with all in_valid = 0 → out_valid = 0, out_data = 0, in_ready = 0 for 5 cycles.
- MODE_SEL sweep, CHANNELS = 16, WIDTH = 32: channel k holds 32'h0 + k, all valid, out_ready = 1, sel = 0..15 one per cycle → out_data = sel of the previous cycle and out_chan matches; sel = 15 gives 32'hF.
- MODE_RR fairness: all 16 inputs valid, out_ready = 1 → out_chan sequence 0,1,…,15,0 on consecutive cycles. in_valid = 16'h0011 → alternating 0,4.
- Backpressure: out_ready = 0 for 3 cycles after the first word → out_data held, in_ready = 0. Release → next channel in RR order is granted with no lost or duplicated word.
- Boundaries:
  - CHANNELS = 5 with sel = 6 in MODE_SEL → no transfer, out_valid falls after the drain.
  - Switch MODE_RR→MODE_SEL→MODE_RR → RR resumes after the retained ptr.
- Async reset with out_valid = 1 and out_ready = 0 → out_valid = 0 immediately (before the next edge). After release, the first RR grant is channel 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the N-to-1 channel mux/arbiter.
// Latency: n/a (no logic).
// Backpressure: n/a.
package mux_arb_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Select width that stays at least one bit wide for tiny channel counts.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_arb_nto1_rr_grant.sv
// Rotating-priority encoder: first request strictly after ptr, wrapping modulo CHANNELS.
// Latency: combinational.
// Backpressure: none; the caller qualifies the grant with its accept condition.
module rr_grant
    import mux_arb_pkg::*;
#(
    parameter int CHANNELS = 16,
    parameter int SEL_W    = clog2_safe(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [CHANNELS-1:0] gnt,
    output logic [SEL_W-1:0]    gnt_idx,
    output logic                gnt_any
);

    logic [SEL_W-1:0] cand;

    // Walk from the farthest candidate back to ptr+1 so the nearest hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int i = CHANNELS; i >= 1; i--) begin
            cand = SEL_W'((int'(ptr) + i) % CHANNELS);
            if (req[cand]) begin
                gnt     = CHANNELS'(1) << cand;
                gnt_idx = cand;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_nto1.sv
// Registered N-to-1 channel mux with fixed-select or round-robin grant.
// Latency: 1 cycle from input handshake to out_data/out_valid.
// Backpressure: a held word with out_ready low deasserts every in_ready; drain+load is bubble-free.
module mux_arb_nto1
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = clog2_safe(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [SEL_W-1:0]    ptr;
    logic [CHANNELS-1:0] sel_gnt;
    logic [CHANNELS-1:0] rr_gnt;
    logic [SEL_W-1:0]    rr_idx;
    logic                rr_any;
    logic [CHANNELS-1:0] gnt;
    logic [SEL_W-1:0]    gnt_idx;
    logic                gnt_any;
    logic [WIDTH-1:0]    gnt_dat;
    logic                accept;
    logic                xfer;

    rr_grant #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_grant (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    // Comparing against every channel index makes an out-of-range sel grant nothing.
    always_comb begin
        sel_gnt = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sel_gnt[k] = (int'(sel) == k) && in_valid[k];
        end
    end

    always_comb begin
        if (mode == MODE_RR) begin
            gnt     = rr_gnt;
            gnt_idx = rr_idx;
            gnt_any = rr_any;
        end else begin
            gnt     = sel_gnt;
            gnt_idx = sel;
            gnt_any = |sel_gnt;
        end
    end

    always_comb begin
        gnt_dat = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (gnt[k]) gnt_dat = in_data[k*WIDTH +: WIDTH];
        end
    end

    assign accept   = !out_valid || out_ready;
    assign xfer     = accept && gnt_any;
    assign in_ready = accept ? gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= SEL_W'(CHANNELS - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_dat;
            out_chan  <= gnt_idx;
            if (mode == MODE_RR) ptr <= gnt_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
